// File: rtl/duck_flock.sv
// duck_flock: up to four independent ducks (fly / hit / fall / escape) sharing one trigger,
// plus a registered sprite-ROM address path for the colour mapper.

module duck_flock #(
    parameter int NUM_DUCKS   = 2,
    parameter int DUCK_W      = 64,
    parameter int DUCK_H      = 64,
    parameter int SHEET_W     = 384,
    parameter int ADDR_W      = 16,
    parameter int X_MIN       = 100,
    parameter int X_MAX       = 400,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 245,
    parameter int X_STEP      = 2,
    parameter int Y_STEP      = 1,
    parameter int FALL_STEP   = 3,
    parameter int SPACING     = 96,
    parameter int ANIM_FRAMES = 10,
    parameter int HIT_FRAMES  = 30
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic                 start,
    input  logic                 trigger,
    input  logic [9:0]           shot_x,
    input  logic [9:0]           shot_y,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    output logic                 is_duck,
    output logic [1:0]           duck_id,
    output logic [ADDR_W-1:0]    duck_addr,
    output logic [NUM_DUCKS-1:0] hit_mask,
    output logic [NUM_DUCKS-1:0] gone_mask,
    output logic                 round_done
);

    localparam int CNT_MAX = (ANIM_FRAMES > HIT_FRAMES) ? ANIM_FRAMES : HIT_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [9:0]       X_MIN_V     = 10'(X_MIN);
    localparam logic [9:0]       X_MAX_V     = 10'(X_MAX);
    localparam logic [9:0]       Y_MIN_V     = 10'(Y_MIN);
    localparam logic [9:0]       Y_MAX_V     = 10'(Y_MAX);
    localparam logic [9:0]       X_STEP_V    = 10'(X_STEP);
    localparam logic [9:0]       Y_STEP_V    = 10'(Y_STEP);
    localparam logic [9:0]       DUCK_W_V    = 10'(DUCK_W);
    localparam logic [9:0]       DUCK_H_V    = 10'(DUCK_H);
    localparam logic [CNT_W-1:0] ANIM_LAST   = CNT_W'(ANIM_FRAMES - 1);
    localparam logic [CNT_W-1:0] HIT_LAST    = CNT_W'(HIT_FRAMES - 1);
    localparam logic [31:0]      ADDR_LIMIT  = 32'((64'd1 << ADDR_W) - 64'd1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FLY  = 3'd1,
        ST_HIT  = 3'd2,
        ST_FALL = 3'd3,
        ST_DOWN = 3'd4,
        ST_GONE = 3'd5
    } duck_state_e;

    duck_state_e      state_q [NUM_DUCKS];
    duck_state_e      state_d [NUM_DUCKS];
    logic [9:0]       x_q     [NUM_DUCKS];
    logic [9:0]       x_d     [NUM_DUCKS];
    logic [9:0]       y_q     [NUM_DUCKS];
    logic [9:0]       y_d     [NUM_DUCKS];
    logic             left_q  [NUM_DUCKS];
    logic             left_d  [NUM_DUCKS];
    logic [2:0]       pose_q  [NUM_DUCKS];
    logic [2:0]       pose_d  [NUM_DUCKS];
    logic [CNT_W-1:0] anim_q  [NUM_DUCKS];
    logic [CNT_W-1:0] anim_d  [NUM_DUCKS];
    logic [CNT_W-1:0] hcnt_q  [NUM_DUCKS];
    logic [CNT_W-1:0] hcnt_d  [NUM_DUCKS];

    logic [9:0]  sdx_s    [NUM_DUCKS];
    logic [9:0]  sdy_s    [NUM_DUCKS];
    logic [9:0]  pdx_s    [NUM_DUCKS];
    logic [9:0]  pdy_s    [NUM_DUCKS];
    logic [10:0] fall_y_s [NUM_DUCKS];

    logic [NUM_DUCKS-1:0] shot_in_s, pix_in_s, done_s;
    logic [NUM_DUCKS-1:0] hit_q, hit_d, gone_q, gone_d;
    logic                 bullet_used_s, pix_found_s;
    logic                 fc_q, tick_q, round_done_q;
    logic                 is_duck_q, is_duck_d;
    logic [1:0]           duck_id_q, duck_id_d;
    logic [ADDR_W-1:0]    duck_addr_q, duck_addr_d;
    logic [31:0]          addr_full_s;

    // Rising-edge detect of the frame strobe; tick is high the cycle after the edge is seen
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            fc_q   <= frame_clk;
            tick_q <= frame_clk & ~fc_q;
        end
    end

    // Per-duck box tests against the crosshair and the current pixel (10-bit wrap = miss)
    always_comb begin
        for (int i = 0; i < NUM_DUCKS; i++) begin
            sdx_s[i]     = shot_x - x_q[i];
            sdy_s[i]     = shot_y - y_q[i];
            pdx_s[i]     = DrawX - x_q[i];
            pdy_s[i]     = DrawY - y_q[i];
            shot_in_s[i] = (sdx_s[i] < DUCK_W_V) && (sdy_s[i] < DUCK_H_V);
            pix_in_s[i]  = ((state_q[i] == ST_FLY) || (state_q[i] == ST_HIT) || (state_q[i] == ST_FALL))
                           && (pdx_s[i] < DUCK_W_V) && (pdy_s[i] < DUCK_H_V);
            done_s[i]    = (state_q[i] == ST_DOWN) || (state_q[i] == ST_GONE);
            fall_y_s[i]  = {1'b0, y_q[i]} + 11'(FALL_STEP);
        end
    end

    // Duck state machines; the bullet is consumed by the lowest-index flying duck it touches
    always_comb begin
        hit_d         = hit_q;
        gone_d        = gone_q;
        bullet_used_s = 1'b0;
        for (int i = 0; i < NUM_DUCKS; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            left_d[i]  = left_q[i];
            pose_d[i]  = pose_q[i];
            anim_d[i]  = anim_q[i];
            hcnt_d[i]  = hcnt_q[i];
            if (start) begin
                state_d[i] = ST_FLY;
                x_d[i]     = 10'(X_MIN + i * SPACING);
                y_d[i]     = Y_MAX_V;
                left_d[i]  = (i % 2) != 0;
                pose_d[i]  = 3'd0;
                anim_d[i]  = '0;
                hcnt_d[i]  = '0;
                hit_d[i]   = 1'b0;
                gone_d[i]  = 1'b0;
            end else begin
                case (state_q[i])
                    ST_FLY: begin
                        if (trigger && shot_in_s[i] && !bullet_used_s) begin
                            bullet_used_s = 1'b1;
                            state_d[i]    = ST_HIT;
                            pose_d[i]     = 3'd3;
                            hcnt_d[i]     = '0;
                            hit_d[i]      = 1'b1;
                        end else if (tick_q) begin
                            if (y_q[i] <= Y_MIN_V) begin
                                state_d[i] = ST_GONE;
                                gone_d[i]  = 1'b1;
                            end else begin
                                if (x_q[i] >= X_MAX_V) begin
                                    left_d[i] = 1'b1;
                                end else if (x_q[i] <= X_MIN_V) begin
                                    left_d[i] = 1'b0;
                                end else begin
                                    left_d[i] = left_q[i];
                                end
                                x_d[i] = left_d[i] ? (x_q[i] - X_STEP_V) : (x_q[i] + X_STEP_V);
                                // Y velocity can only ever be re-set to a climb, so it is implicit
                                y_d[i] = y_q[i] - Y_STEP_V;
                                if (anim_q[i] == ANIM_LAST) begin
                                    anim_d[i] = '0;
                                    pose_d[i] = (pose_q[i] == 3'd2) ? 3'd0 : (pose_q[i] + 3'd1);
                                end else begin
                                    anim_d[i] = anim_q[i] + CNT_W'(1);
                                end
                            end
                        end else begin
                            state_d[i] = ST_FLY;
                        end
                    end
                    ST_HIT: begin
                        if (tick_q) begin
                            if (hcnt_q[i] == HIT_LAST) begin
                                state_d[i] = ST_FALL;
                                pose_d[i]  = 3'd4;
                                anim_d[i]  = '0;
                            end else begin
                                hcnt_d[i] = hcnt_q[i] + CNT_W'(1);
                            end
                        end else begin
                            state_d[i] = ST_HIT;
                        end
                    end
                    ST_FALL: begin
                        if (tick_q) begin
                            if (fall_y_s[i] >= {1'b0, Y_MAX_V}) begin
                                y_d[i]     = Y_MAX_V;
                                state_d[i] = ST_DOWN;
                            end else begin
                                y_d[i] = fall_y_s[i][9:0];
                                if (anim_q[i] == ANIM_LAST) begin
                                    anim_d[i] = '0;
                                    pose_d[i] = (pose_q[i] == 3'd4) ? 3'd5 : 3'd4;
                                end else begin
                                    anim_d[i] = anim_q[i] + CNT_W'(1);
                                end
                            end
                        end else begin
                            state_d[i] = ST_FALL;
                        end
                    end
                    default: state_d[i] = state_q[i];
                endcase
            end
        end
    end

    // Sprite lookup for the lowest-index covering duck; out-of-range addresses read as 0
    always_comb begin
        is_duck_d   = 1'b0;
        duck_id_d   = 2'd0;
        duck_addr_d = '0;
        addr_full_s = 32'd0;
        pix_found_s = 1'b0;
        for (int i = 0; i < NUM_DUCKS; i++) begin
            if (pix_in_s[i] && !pix_found_s) begin
                pix_found_s = 1'b1;
                is_duck_d   = 1'b1;
                duck_id_d   = 2'(i);
                addr_full_s = (32'(pdy_s[i]) + (left_q[i] ? 32'(DUCK_H) : 32'd0)) * 32'(SHEET_W)
                              + 32'(pdx_s[i]) + 32'(pose_q[i]) * 32'(DUCK_W);
                duck_addr_d = (addr_full_s > ADDR_LIMIT) ? '0 : ADDR_W'(addr_full_s);
            end else begin
                pix_found_s = pix_found_s;
            end
        end
    end

    // State, result masks and pixel outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_DUCKS; i++) begin
                state_q[i] <= ST_IDLE;
                x_q[i]     <= 10'd0;
                y_q[i]     <= 10'd0;
                left_q[i]  <= 1'b0;
                pose_q[i]  <= 3'd0;
                anim_q[i]  <= '0;
                hcnt_q[i]  <= '0;
            end
            hit_q        <= '0;
            gone_q       <= '0;
            round_done_q <= 1'b0;
            is_duck_q    <= 1'b0;
            duck_id_q    <= 2'd0;
            duck_addr_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_DUCKS; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                left_q[i]  <= left_d[i];
                pose_q[i]  <= pose_d[i];
                anim_q[i]  <= anim_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
            hit_q        <= hit_d;
            gone_q       <= gone_d;
            round_done_q <= &done_s;
            is_duck_q    <= is_duck_d;
            duck_id_q    <= duck_id_d;
            duck_addr_q  <= duck_addr_d;
        end
    end

    assign is_duck    = is_duck_q;
    assign duck_id    = duck_id_q;
    assign duck_addr  = duck_addr_q;
    assign hit_mask   = hit_q;
    assign gone_mask  = gone_q;
    assign round_done = round_done_q;

endmodule

// File: tb/tb_duck_flock.sv
// Directed scoreboard bench for duck_flock (default parameters, two ducks).

module tb_duck_flock;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        start = 1'b0;
    logic        trigger = 1'b0;
    logic [9:0]  shot_x = 10'd0;
    logic [9:0]  shot_y = 10'd0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        is_duck;
    logic [1:0]  duck_id;
    logic [15:0] duck_addr;
    logic [1:0]  hit_mask;
    logic [1:0]  gone_mask;
    logic        round_done;

    always #5 Clk = ~Clk;

    duck_flock dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .start      (start),
        .trigger    (trigger),
        .shot_x     (shot_x),
        .shot_y     (shot_y),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .is_duck    (is_duck),
        .duck_id    (duck_id),
        .duck_addr  (duck_addr),
        .hit_mask   (hit_mask),
        .gone_mask  (gone_mask),
        .round_done (round_done)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q [$];

    // Reference duck model: 0 idle, 1 fly, 2 hit, 3 fall, 4 down, 5 gone
    int mst [2];
    int mx [2];
    int my [2];
    int mpose [2];
    int manim [2];
    int mhc [2];
    bit mleft [2];

    function automatic logic [31:0] pix(input int v, input int id, input int addr);
        logic [31:0] r;
        r = (32'(v) << 18) | (32'(id) << 16) | 32'(addr);
        return r;
    endfunction

    function automatic logic [31:0] model_pix(input int px, input int py);
        int dxo, dyo, a;
        for (int i = 0; i < 2; i++) begin
            if (mst[i] >= 1 && mst[i] <= 3) begin
                dxo = (px - mx[i]) & 1023;
                dyo = (py - my[i]) & 1023;
                if (dxo < 64 && dyo < 64) begin
                    a = (dyo + (mleft[i] ? 64 : 0)) * 384 + dxo + mpose[i] * 64;
                    if (a > 65535) a = 0;
                    return pix(1, i, a);
                end
            end
        end
        return 32'd0;
    endfunction

    task automatic m_start();
        for (int i = 0; i < 2; i++) begin
            mst[i] = 1; mx[i] = 100 + i * 96; my[i] = 245;
            mleft[i] = (i % 2) == 1; mpose[i] = 0; manim[i] = 0; mhc[i] = 0;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            mst[i] = 0; mx[i] = 0; my[i] = 0; mleft[i] = 0; mpose[i] = 0; manim[i] = 0; mhc[i] = 0;
        end
    endtask

    // Returns the index of the duck the model says is hit, or -1
    function automatic int m_shot(input int sx, input int sy);
        for (int i = 0; i < 2; i++) begin
            if (mst[i] == 1 && ((sx - mx[i]) & 1023) < 64 && ((sy - my[i]) & 1023) < 64) begin
                mst[i] = 2; mpose[i] = 3; mhc[i] = 0;
                return i;
            end
        end
        return -1;
    endfunction

    task automatic m_tick(input int skip);
        for (int i = 0; i < 2; i++) begin
            if (i != skip) begin
                case (mst[i])
                    1: begin
                        if (my[i] <= 0) begin
                            mst[i] = 5;
                        end else begin
                            if (mx[i] >= 400) mleft[i] = 1;
                            else if (mx[i] <= 100) mleft[i] = 0;
                            mx[i] = mx[i] + (mleft[i] ? -2 : 2);
                            my[i] = my[i] - 1;
                            manim[i]++;
                            if (manim[i] == 10) begin manim[i] = 0; mpose[i] = (mpose[i] + 1) % 3; end
                        end
                    end
                    2: begin
                        mhc[i]++;
                        if (mhc[i] == 30) begin mst[i] = 3; mpose[i] = 4; manim[i] = 0; end
                    end
                    3: begin
                        my[i] = my[i] + 3;
                        if (my[i] >= 245) begin
                            my[i] = 245; mst[i] = 4;
                        end else begin
                            manim[i]++;
                            if (manim[i] == 10) begin manim[i] = 0; mpose[i] = (mpose[i] == 4) ? 5 : 4; end
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            exp = sb_q.pop_front();
            assert (obs === exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_q.push_back(exp);
        check(tag, obs);
    endtask

    task automatic check_all_zero(input string tag);
        expect_now({tag, "_is_duck"}, 32'(is_duck), 32'd0);
        expect_now({tag, "_duck_id"}, 32'(duck_id), 32'd0);
        expect_now({tag, "_duck_addr"}, 32'(duck_addr), 32'd0);
        expect_now({tag, "_hit_mask"}, 32'(hit_mask), 32'd0);
        expect_now({tag, "_gone_mask"}, 32'(gone_mask), 32'd0);
        expect_now({tag, "_round_done"}, 32'(round_done), 32'd0);
    endtask

    task automatic probe(input string tag, input int px, input int py, input logic [31:0] exp);
        @(negedge Clk);
        DrawX = 10'(px);
        DrawY = 10'(py);
        sb_q.push_back(exp);
        @(negedge Clk);
        check(tag, pix(int'(is_duck), int'(duck_id), int'(duck_addr)));
    endtask

    task automatic do_tick();
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        m_tick(-1);
    endtask

    task automatic do_start();
        @(negedge Clk);
        start = 1'b1;
        m_start();
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic fire(input string tag, input int sx, input int sy, input logic [1:0] exp_mask);
        int idx;
        @(negedge Clk);
        trigger = 1'b1;
        shot_x  = 10'(sx);
        shot_y  = 10'(sy);
        idx = m_shot(sx, sy);
        sb_q.push_back(32'(exp_mask));
        @(negedge Clk);
        trigger = 1'b0;
        check(tag, 32'(hit_mask));
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        Reset = 1'b0;

        // Launch and first tick
        do_start();
        probe("launch_duck0", 100, 245, pix(1, 0, 0));
        probe("launch_duck1", 196, 245, pix(1, 1, 24576));
        probe("launch_left_of_box", 99, 245, pix(0, 0, 0));
        do_tick();
        probe("tick1_duck0", 102, 244, pix(1, 0, 0));
        probe("tick1_duck1", 194, 244, pix(1, 1, 24576));
        probe("tick1_duck0_moved", 101, 244, pix(0, 0, 0));

        // Hit, hang, fall, clamp
        fire("hit_duck0", 110, 250, 2'b01);
        probe("hit_pose3", 102, 244, pix(1, 0, 192));
        repeat (29) do_tick();
        probe("hang_29_ticks", 102, 244, pix(1, 0, 192));
        do_tick();
        probe("fall_pose4", 102, 244, pix(1, 0, 256));
        do_tick();
        probe("down_not_drawn", 102, 245, pix(0, 0, 0));
        probe("duck1_model_pos", mx[1] + 3, my[1] + 4, model_pix(mx[1] + 3, my[1] + 4));
        expect_now("hit_mask_sticky", 32'(hit_mask), 32'd1);
        expect_now("round_not_done", 32'(round_done), 32'd0);

        // Relaunch clears masks; overlapping ducks take one bullet each, lowest index first
        do_start();
        expect_now("restart_hit_clear", 32'(hit_mask), 32'd0);
        repeat (16) do_tick();
        fire("overlap_first", 170, 234, 2'b01);
        fire("overlap_second", 170, 234, 2'b11);
        fire("overlap_ignored", 170, 234, 2'b11);

        // Trigger coincident with a tick, then reset mid-fall
        do_start();
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        trigger = 1'b1;
        shot_x = 10'd105;
        shot_y = 10'd250;
        sb_q.push_back(32'd1);
        m_tick(m_shot(105, 250));
        @(negedge Clk);
        trigger = 1'b0;
        check("tick_and_hit_mask", 32'(hit_mask));
        probe("tick_and_hit_no_move", 100, 245, pix(1, 0, 192));
        probe("tick_and_hit_other_moves", 194, 244, pix(1, 1, 24576));
        repeat (30) do_tick();
        probe("mid_fall", 100, 245, pix(1, 0, 256));
        @(negedge Clk);
        Reset = 1'b1;
        m_reset();
        @(negedge Clk);
        check_all_zero("mid_reset");
        Reset = 1'b0;
        probe("after_reset_idle", 100, 245, pix(0, 0, 0));
        do_tick();
        probe("idle_after_tick", 100, 245, pix(0, 0, 0));

        // Uninterrupted flight: pose/facing checks on the way, then both ducks escape
        do_start();
        for (int t = 1; t <= 400; t++) begin
            do_tick();
            if (t == 145) probe("pose2_addr", 395, 110, pix(1, 0, 3973));
            if (t == 151) probe("turn_left_addr", 398, 95, pix(1, 0, 24960));
            if (t == 245) expect_now("not_gone_yet", 32'(gone_mask), 32'd0);
            if (mst[0] == 5 && mst[1] == 5) break;
        end
        expect_now("gone_mask_all", 32'(gone_mask), 32'd3);
        expect_now("round_done_lag", 32'(round_done), 32'd0);
        @(negedge Clk);
        expect_now("round_done_rise", 32'(round_done), 32'd1);
        expect_now("escape_no_hits", 32'(hit_mask), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
